// File: rtl/vga_display_ctrl.sv
// Run-control and timing sequencer for the VGA frame counter.
// It divides clk into pixel ticks, drives the counter controls, registers sync/DE and schedules frame-boundary events.
module vga_display_ctrl #(
  parameter int H_SIZE    = 10,
  parameter int V_SIZE    = 10,
  parameter int PIX_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic              buf_swap_req,
  input  logic [H_SIZE-1:0] fc_hcount,
  input  logic [V_SIZE-1:0] fc_vcount,
  input  logic              frame_end,
  input  logic              frame_display,
  output logic              fc_clear,
  output logic              fc_enable,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_de,
  output logic              pix_valid,
  output logic              buf_sel,
  output logic              buf_swap_ack,
  output logic              running,
  output logic [15:0]       frame_cnt
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  // One extra bit keeps the sync window bounds from overflowing the count width.
  localparam logic [H_SIZE:0] H_SYNC_BEG = (H_SIZE + 1)'(H_DISPLAY + H_FRONT);
  localparam logic [H_SIZE:0] H_SYNC_END = (H_SIZE + 1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [V_SIZE:0] V_SYNC_BEG = (V_SIZE + 1)'(V_DISPLAY + V_FRONT);
  localparam logic [V_SIZE:0] V_SYNC_END = (V_SIZE + 1)'(V_DISPLAY + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             pix_tick;
  logic             boundary;
  logic             swap_pend;
  logic             swap_now;
  logic             h_active;
  logic             v_active;

  assign pix_tick  = (state != IDLE) && (div_cnt == DIV_LAST);
  assign boundary  = pix_tick && frame_end;
  assign running   = (state != IDLE);
  assign fc_clear  = (state == IDLE);
  assign fc_enable = pix_tick;

  assign h_active = ({1'b0, fc_hcount} >= H_SYNC_BEG) && ({1'b0, fc_hcount} < H_SYNC_END);
  assign v_active = ({1'b0, fc_vcount} >= V_SYNC_BEG) && ({1'b0, fc_vcount} < V_SYNC_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start while draining cancels the pending stop, even on the boundary tick itself.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ctrl_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (ctrl_stop) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (ctrl_start) begin
          state_next = RUN;
        end else if (boundary) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if ((state == IDLE) || pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync <= ~SYNC_POL;
      vga_vsync <= ~SYNC_POL;
      vga_de    <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      vga_hsync <= (running && h_active) ? SYNC_POL : ~SYNC_POL;
      vga_vsync <= (running && v_active) ? SYNC_POL : ~SYNC_POL;
      vga_de    <= frame_display && running;
      pix_valid <= fc_enable;
    end
  end

  // While idle nothing is being scanned out, so a swap is safe immediately.
  always_comb begin
    swap_now = 1'b0;
    if (state == IDLE) begin
      swap_now = swap_pend || buf_swap_req;
    end else if (boundary) begin
      swap_now = swap_pend || buf_swap_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      swap_pend    <= 1'b0;
      buf_sel      <= 1'b0;
      buf_swap_ack <= 1'b0;
    end else begin
      buf_swap_ack <= swap_now;
      if (swap_now) begin
        swap_pend <= 1'b0;
        buf_sel   <= ~buf_sel;
      end else if (buf_swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (boundary) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
